// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular write FIFO.
// Frames are start bit, DATA_BITS data bits LSB first, optional parity,
// then STOP_BITS stop bits, each bit held for CYCLES_PER_BIT clocks.
// Ports:
//   i_clk     system clock (rising edge)
//   i_rst_n   asynchronous active-low reset
//   i_wr_w    write strobe, one cycle per word
//   i_data_w  word to enqueue
//   o_full    FIFO full, writes dropped while high
//   o_level   words currently held in the FIFO
//   o_busy    frame in progress or FIFO non-empty
//   o_tx_w    serial line, idles high
module uart_tx_fifo #(
  parameter int unsigned CLOCK_RATE     = 50000000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE,
  parameter int unsigned PARITY         = 0,
  parameter int unsigned STOP_BITS      = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_w,
  input  logic [DATA_BITS-1:0]          i_data_w,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_tx_w
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CYCLES_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_n;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [BW-1:0]          bit_q, bit_n;
  logic                   stop_q, stop_n;
  logic [DATA_BITS-1:0]   shreg_q, shreg_n;
  logic                   par_q, par_n;
  logic                   tx_q, tx_n;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_n;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_n;
  logic [LW-1:0]          level_q, level_n;
  logic                   full_q, full_n;
  logic                   busy_q, busy_n;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   head;
  logic                   push;
  logic                   pop;
  logic                   bit_end;
  logic                   fifo_has_data;

  // Full comes from the registered level, so a same-cycle pop never frees a slot for a write.
  assign push          = i_wr_w & ~full_q;
  assign head          = mem[rd_ptr_q];
  assign bit_end       = (cnt_q == '0);
  assign fifo_has_data = (level_q != '0);

  // Next-state, datapath and FIFO bookkeeping.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    stop_n   = stop_q;
    shreg_n  = shreg_q;
    par_n    = par_q;
    tx_n     = tx_q;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_n = CNT_MAX;
        tx_n  = 1'b1;
        if (fifo_has_data) begin
          pop     = 1'b1;
          shreg_n = head;
          par_n   = ^head;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_n   = CNT_MAX;
          bit_n   = '0;
          tx_n    = shreg_q[0];
          state_n = S_DATA;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_n = CNT_MAX;
          if (bit_q == BIT_LAST) begin
            stop_n = 1'b0;
            if (PARITY != 0) begin
              // Even mode sends the data XOR, odd mode its inverse.
              tx_n    = (PARITY == 2) ? par_q : ~par_q;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            bit_n   = bit_q + BW'(1);
            tx_n    = shreg_q[1];
            shreg_n = shreg_q >> 1;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          cnt_n   = CNT_MAX;
          stop_n  = 1'b0;
          tx_n    = 1'b1;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      S_STOP: begin
        if (bit_end) begin
          cnt_n = CNT_MAX;
          if (stop_q == STOP_LAST) begin
            // Chain straight into the next start bit when more words are queued.
            if (fifo_has_data) begin
              pop     = 1'b1;
              shreg_n = head;
              par_n   = ^head;
              tx_n    = 1'b0;
              state_n = S_START;
            end else begin
              tx_n    = 1'b1;
              state_n = S_IDLE;
            end
          end else begin
            stop_n = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      default: begin
        cnt_n   = CNT_MAX;
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase

    wr_ptr_n = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_n = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    level_n  = level_q + LW'(push) - LW'(pop);
    full_n   = (level_n == LVL_FULL);
    busy_n   = (state_n != S_IDLE) | (level_n != '0);
  end

  // Control and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_MAX;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      bit_q    <= bit_n;
      stop_q   <= stop_n;
      shreg_q  <= shreg_n;
      par_q    <= par_n;
      tx_q     <= tx_n;
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      level_q  <= level_n;
      full_q   <= full_n;
      busy_q   <= busy_n;
    end
  end

  // FIFO storage, no reset needed since the level gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_data_w;
    end
  end

  assign o_full  = full_q;
  assign o_level = level_q;
  assign o_busy  = busy_q;
  assign o_tx_w  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances (no parity, even, odd, two stop
// bits) share stimulus; per-instance frame monitors pop expected words
// from scoreboard queues and compare whole sampled frames.
module tb_uart_tx_fifo;

  localparam int unsigned CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] wdata = 8'h00;

  logic       full  [4];
  logic       busy  [4];
  logic       tx    [4];
  logic [2:0] level [4];

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_none (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_w(wr), .i_data_w(wdata),
    .o_full(full[0]), .o_level(level[0]), .o_busy(busy[0]), .o_tx_w(tx[0]));

  uart_tx_fifo #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_w(wr), .i_data_w(wdata),
    .o_full(full[1]), .o_level(level[1]), .o_busy(busy[1]), .o_tx_w(tx[1]));

  uart_tx_fifo #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_w(wr), .i_data_w(wdata),
    .o_full(full[2]), .o_level(level[2]), .o_busy(busy[2]), .o_tx_w(tx[2]));

  uart_tx_fifo #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_w(wr), .i_data_w(wdata),
    .o_full(full[3]), .o_level(level[3]), .o_busy(busy[3]), .o_tx_w(tx[3]));

  // Expected per-clock line samples for one frame, sample 0 = first start-bit clock.
  function automatic logic [63:0] frame_samples(input logic [7:0] d, input int par,
                                                input int stp, output int unsigned n);
    logic [15:0] b;
    logic [63:0] r;
    int unsigned nb;
    int unsigned ones;
    b    = '0;
    r    = '0;
    nb   = 0;
    ones = 0;
    b[nb] = 1'b0;
    nb++;
    for (int i = 0; i < 8; i++) begin
      b[nb] = d[i];
      nb++;
      if (d[i]) ones++;
    end
    if (par != 0) begin
      b[nb] = (par == 2) ? ones[0] : ~ones[0];
      nb++;
    end
    for (int s = 0; s < stp; s++) begin
      b[nb] = 1'b1;
      nb++;
    end
    n = nb * CPB;
    for (int unsigned k = 0; k < n; k++) r[k] = b[k / CPB];
    return r;
  endfunction

  // One frame monitor and scoreboard queue per instance.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    localparam int P = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int S = (g == 3) ? 2 : 1;
    logic [7:0]  q [$];
    logic [63:0] got;
    logic [63:0] expv;
    logic [7:0]  w;
    int unsigned flen     = 0;
    int unsigned pos      = 0;
    int unsigned frames   = 0;
    int unsigned b2b      = 0;
    int unsigned last_end = 32'hFFFF_FF00;

    always @(negedge clk) begin
      if (!rst_n) begin
        flen     = 0;
        pos      = 0;
        last_end = 32'hFFFF_FF00;
        q.delete();
      end else if (flen == 0) begin
        if (tx[g] == 1'b0) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected dut%0d: start bit seen, required idle line (empty scoreboard)", g);
            w = 8'h00;
          end else begin
            w = q.pop_front();
          end
          expv = frame_samples(w, P, S, flen);
          if (cyc == last_end + 1) b2b++;
          got    = '0;
          got[0] = tx[g];
          pos    = 1;
        end
      end else begin
        got[pos] = tx[g];
        pos++;
        if (pos == flen) begin
          total++;
          if (got !== expv) begin
            bad++;
            $display("FAIL frame dut%0d word %02h: got %016h required %016h", g, w, got, expv);
          end
          frames++;
          last_end = cyc;
          flen     = 0;
        end
      end
    end
  end

  task automatic push_all(input logic [7:0] d);
    g_mon[0].q.push_back(d);
    g_mon[1].q.push_back(d);
    g_mon[2].q.push_back(d);
    g_mon[3].q.push_back(d);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while ((busy[0] || busy[1] || busy[2] || busy[3] ||
            g_mon[0].flen != 0 || g_mon[1].flen != 0 ||
            g_mon[2].flen != 0 || g_mon[3].flen != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if (tx[0] !== 1'b1 || full[0] !== 1'b0 || level[0] !== 3'd0 || busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: tx=%b full=%b level=%0d busy=%b required tx=1 full=0 level=0 busy=0",
               tx[0], full[0], level[0], busy[0]);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Single word into idle block: latency, frame length, parity bit value.
  task automatic run_frame(input logic [7:0] d, input logic ev, input logic od, input string tag);
    int unsigned n;
    logic pe, po;
    @(negedge clk);
    wr    = 1'b1;
    wdata = d;
    push_all(d);
    @(negedge clk);
    wr = 1'b0;
    total++;
    if (tx[0] !== 1'b1 || level[0] !== 3'd1 || busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept: tx=%b level=%0d busy=%b required tx=1 level=1 busy=1", tag, tx[0], level[0], busy[0]);
    end
    @(negedge clk);
    total++;
    if (tx[0] !== 1'b0 || level[0] !== 3'd0) begin
      bad++;
      $display("FAIL %s_pop_latency: tx=%b level=%0d required tx=0 level=0", tag, tx[0], level[0]);
    end
    n  = 0;
    pe = 1'bx;
    po = 1'bx;
    while (busy[0] && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 37) begin
        pe = tx[1];
        po = tx[2];
      end
    end
    total++;
    if (n != 40) begin
      bad++;
      $display("FAIL %s_len_none: busy clocks=%0d required 40", tag, n);
    end
    while (busy[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 44) begin
      bad++;
      $display("FAIL %s_len_parity: busy clocks=%0d required 44", tag, n);
    end
    total++;
    if (pe !== ev || po !== od) begin
      bad++;
      $display("FAIL %s_parity_bit: even=%b odd=%b required even=%b odd=%b", tag, pe, po, ev, od);
    end
    wait_idle(tag);
  endtask

  task automatic test_single_frame;
    run_frame(8'hA5, 1'b0, 1'b1, "single");
  endtask

  task automatic test_parity;
    run_frame(8'h01, 1'b1, 1'b0, "parity");
  endtask

  // Six consecutive writes plus a write held across the first pop while full.
  task automatic test_fifo_fill;
    logic [7:0] words [6];
    int unsigned f0, f3, b0, b1, b3, n;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    f0 = g_mon[0].frames;
    f3 = g_mon[3].frames;
    b0 = g_mon[0].b2b;
    b1 = g_mon[1].b2b;
    b3 = g_mon[3].b2b;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) begin
        total++;
        if (full[0] !== 1'b1 || level[0] !== 3'd4 || full[3] !== 1'b1) begin
          bad++;
          $display("FAIL fill_full: full=%b level=%0d full_s2=%b required full=1 level=4 full_s2=1",
                   full[0], level[0], full[3]);
        end
      end
      wr    = 1'b1;
      wdata = words[i];
      if (i < 5) push_all(words[i]);
    end
    @(negedge clk);
    total++;
    if (level[0] !== 3'd4 || full[0] !== 1'b1) begin
      bad++;
      $display("FAIL fill_drop: level=%0d full=%b required level=4 full=1", level[0], full[0]);
    end
    // Keep writing while full until the head frame finishes and pops.
    wdata = 8'hEE;
    n = 0;
    while (level[0] == 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    wr = 1'b0;
    total++;
    if (level[0] !== 3'd3 || full[0] !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_write: level=%0d full=%b after %0d cycles required level=3 full=0", level[0], full[0], n);
    end
    wait_idle("fill");
    total++;
    if (g_mon[0].frames - f0 != 5 || g_mon[3].frames - f3 != 5) begin
      bad++;
      $display("FAIL fill_frames: none=%0d stop2=%0d required 5 each", g_mon[0].frames - f0, g_mon[3].frames - f3);
    end
    total++;
    if (g_mon[0].b2b - b0 != 4 || g_mon[1].b2b - b1 != 4 || g_mon[3].b2b - b3 != 4) begin
      bad++;
      $display("FAIL back_to_back: gapless starts none=%0d even=%0d stop2=%0d required 4 each",
               g_mon[0].b2b - b0, g_mon[1].b2b - b1, g_mon[3].b2b - b3);
    end
  endtask

  // Asynchronous reset during data bit 3, then a fresh frame.
  task automatic test_reset_mid_frame;
    int unsigned f0, f3;
    @(negedge clk);
    wr    = 1'b1;
    wdata = 8'h3C;
    push_all(8'h3C);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx[0] !== 1'b1 || level[0] !== 3'd0 || busy[0] !== 1'b0 || tx[3] !== 1'b1 || full[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: tx=%b level=%0d busy=%b tx_s2=%b full=%b required tx=1 level=0 busy=0 tx_s2=1 full=0",
               tx[0], level[0], busy[0], tx[3], full[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    f0 = g_mon[0].frames;
    f3 = g_mon[3].frames;
    @(negedge clk);
    wr    = 1'b1;
    wdata = 8'h5A;
    push_all(8'h5A);
    @(negedge clk);
    wr = 1'b0;
    wait_idle("reset_mid");
    total++;
    if (g_mon[0].frames - f0 != 1 || g_mon[3].frames - f3 != 1) begin
      bad++;
      $display("FAIL reset_recover: frames none=%0d stop2=%0d required 1 each", g_mon[0].frames - f0, g_mon[3].frames - f3);
    end
  endtask

  // Nine paced writes so both pointers wrap twice.
  task automatic test_wrap_two_stop;
    int unsigned f0, f3, n, qs;
    logic [7:0] d;
    f0 = g_mon[0].frames;
    f3 = g_mon[3].frames;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      @(negedge clk);
      while ((full[0] || full[1] || full[2] || full[3]) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 1000) begin
        total++;
        bad++;
        $display("FAIL wrap_full_timeout: FIFO stayed full %0d cycles, required space", n);
      end
      d     = 8'($urandom_range(0, 255));
      wr    = 1'b1;
      wdata = d;
      push_all(d);
      @(negedge clk);
      wr = 1'b0;
    end
    wait_idle("wrap");
    total++;
    if (g_mon[0].frames - f0 != 9 || g_mon[3].frames - f3 != 9) begin
      bad++;
      $display("FAIL wrap_frames: none=%0d stop2=%0d required 9 each", g_mon[0].frames - f0, g_mon[3].frames - f3);
    end
    qs = g_mon[0].q.size() + g_mon[1].q.size() + g_mon[2].q.size() + g_mon[3].q.size();
    total++;
    if (qs != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d words untransmitted, required 0", qs);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_fifo_fill();
    test_reset_mid_frame();
    test_wrap_two_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
